// File: rtl/memoria_datos_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
// Signal names keep the pipeline's i_/o_ naming as seen from the controller.
interface memoria_datos_ctrl_if #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned TNBITS = 2
);
    logic              i_Valido;
    logic              i_LeerMem;
    logic              i_EscribirMem;
    logic [NBITS-1:0]  i_Direccion;
    logic [NBITS-1:0]  i_DatoEscribir;
    logic [TNBITS-1:0] i_Tamano;
    logic [NBITS-1:0]  o_DatoLeido;
    logic              o_Listo;
    logic              o_Ocupado;
    logic              o_ErrorAlin;

    // Pipeline side: drives requests, observes completion and stall.
    modport master (
        output i_Valido, i_LeerMem, i_EscribirMem, i_Direccion, i_DatoEscribir, i_Tamano,
        input  o_DatoLeido, o_Listo, o_Ocupado, o_ErrorAlin
    );

    // Controller side.
    modport slave (
        input  i_Valido, i_LeerMem, i_EscribirMem, i_Direccion, i_DatoEscribir, i_Tamano,
        output o_DatoLeido, o_Listo, o_Ocupado, o_ErrorAlin
    );
endinterface

// File: rtl/memoria_datos_ctrl.sv
// MEM-stage data memory controller: one load/store at a time, byte-lane stores,
// right-aligned zero-filled load data, programmable wait states.
// Optional feature macro: MEMDATOS_DEBUG_EN adds a registered debug word-read port.
// Byte-lane logic assumes a 32-bit word (four 8-bit lanes).
module memoria_datos_ctrl #(
    parameter int unsigned NBITS       = 32,
    parameter int unsigned ADDRBITS    = 8,
    parameter int unsigned TNBITS      = 2,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNTBITS     = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    memoria_datos_ctrl_if.slave bus
`ifdef MEMDATOS_DEBUG_EN
    ,
    input  logic [ADDRBITS-1:0] i_DebugDir,
    output logic [NBITS-1:0]    o_DebugDato
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDRBITS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESO = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam logic [TNBITS-1:0] SZ_WORD = TNBITS'(0);
    localparam logic [TNBITS-1:0] SZ_BYTE = TNBITS'(1);
    localparam logic [TNBITS-1:0] SZ_HALF = TNBITS'(2);

    logic [NBITS-1:0] mem [DEPTH];

    logic [1:0]          state_q, state_d;
    logic [CNTBITS-1:0]  cnt_q, cnt_d;
    logic [ADDRBITS+1:0] dir_q;
    logic [NBITS-1:0]    dato_q;
    logic [TNBITS-1:0]   tam_q;
    logic                esc_q;
    logic [NBITS-1:0]    dato_leido_q;

    logic                req;
    logic                mal_alin;
    logic                acceso;
    logic                escritura;
    logic                lectura;
    logic [ADDRBITS-1:0] word_idx;
    logic [1:0]          lane;
    logic [3:0]          be;
    logic [NBITS-1:0]    wdata;
    logic [NBITS-1:0]    palabra;
    logic [NBITS-1:0]    rdata;

    // Address bits above the array are discarded, so addresses wrap modulo the depth.
    logic unused_dir;
    assign unused_dir = ^bus.i_Direccion[NBITS-1:ADDRBITS+2];

    assign req      = bus.i_Valido & (bus.i_LeerMem | bus.i_EscribirMem);
    assign word_idx = dir_q[ADDRBITS+1:2];
    assign lane     = dir_q[1:0];

    // Alignment/size check on the incoming request.
    always_comb begin
        mal_alin = 1'b0;
        case (bus.i_Tamano)
            SZ_WORD: mal_alin = (bus.i_Direccion[1:0] != 2'b00);
            SZ_BYTE: mal_alin = 1'b0;
            SZ_HALF: mal_alin = bus.i_Direccion[0];
            default: mal_alin = 1'b1;
        endcase
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acceso  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = CNTBITS'(WAIT_CYCLES);
                    state_d = mal_alin ? ERROR : ACCESO;
                end
            end
            ACCESO: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTBITS'(1);
                end else begin
                    acceso  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset on the access edge must abort the access, including a pending store.
    assign escritura = acceso & esc_q & ~i_reset;
    assign lectura   = acceso & ~esc_q & ~i_reset;

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the request when it is accepted in IDLE; a store wins over a load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dir_q  <= '0;
            dato_q <= '0;
            tam_q  <= '0;
            esc_q  <= 1'b0;
        end else if (state_q == IDLE && req) begin
            dir_q  <= bus.i_Direccion[ADDRBITS+1:0];
            dato_q <= bus.i_DatoEscribir;
            tam_q  <= bus.i_Tamano;
            esc_q  <= bus.i_EscribirMem;
        end
    end

    // Little-endian lane enables; store data replicated so each lane sees its bytes.
    always_comb begin
        be    = 4'b1111;
        wdata = dato_q;
        case (tam_q)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{dato_q[7:0]}};
            end
            SZ_HALF: begin
                be    = dir_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{dato_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = dato_q;
            end
        endcase
    end

    // Memory array: byte-lane writes, never cleared by reset.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 4; l++) begin
            if (escritura && be[l]) begin
                mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    // Right-align the selected byte/half of the addressed word, zero-filled.
    always_comb begin
        palabra = mem[word_idx];
        case (tam_q)
            SZ_BYTE: rdata = {{(NBITS-8){1'b0}}, palabra[{lane, 3'b000} +: 8]};
            SZ_HALF: rdata = {{(NBITS-16){1'b0}}, palabra[{dir_q[1], 4'b0000} +: 16]};
            default: rdata = palabra;
        endcase
    end

    // Load result register; holds until the next completed load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dato_leido_q <= '0;
        end else if (lectura) begin
            dato_leido_q <= rdata;
        end
    end

    assign bus.o_DatoLeido = dato_leido_q;
    assign bus.o_Listo     = (state_q == FIN);
    assign bus.o_ErrorAlin = (state_q == ERROR);
    assign bus.o_Ocupado   = (state_q != IDLE);

`ifdef MEMDATOS_DEBUG_EN
    // Debug word read, independent of the request FSM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_DebugDato <= '0;
        end else begin
            o_DebugDato <= mem[i_DebugDir];
        end
    end
`endif

endmodule

// File: tb/tb_memoria_datos_ctrl.sv
// Self-checking bench for memoria_datos_ctrl: directed vector table, hand-written
// multi-cycle sequences and random requests checked against a byte-array model.
module tb_memoria_datos_ctrl;

    localparam int unsigned W = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memoria_datos_ctrl_if #(.NBITS(32), .TNBITS(2)) bus ();

`ifdef MEMDATOS_DEBUG_EN
    logic [7:0]  dbg_dir;
    logic [31:0] dbg_dato;
`endif

    memoria_datos_ctrl #(
        .NBITS(32), .ADDRBITS(8), .TNBITS(2), .WAIT_CYCLES(W), .CNTBITS(4)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
`ifdef MEMDATOS_DEBUG_EN
        ,
        .i_DebugDir(dbg_dir),
        .o_DebugDato(dbg_dato)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-addressed reference memory (1024 bytes = 256 words) and last load result.
    logic [7:0]  model [1024];
    logic [31:0] model_dato = '0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        int          kind;      // 0 ignored, 1 completes, 2 alignment error
        logic [31:0] exp_dato;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour from the request rules, byte by byte.
    function automatic void model_req(input logic rd, input logic wr, input logic [1:0] sz,
                                      input logic [31:0] a, input logic [31:0] d,
                                      output int kind, output logic [31:0] dato);
        logic [9:0] b;
        int base;
        b    = a[9:0];
        base = int'(b) & ~3;
        if (!(rd || wr)) begin
            kind = 0;
        end else if (sz == 2'd3 || (sz == 2'd2 && a[0]) || (sz == 2'd0 && a[1:0] != 2'd0)) begin
            kind = 2;
        end else begin
            kind = 1;
            if (wr) begin
                if (sz == 2'd0) begin
                    for (int i = 0; i < 4; i++) model[base + i] = d[8*i +: 8];
                end else if (sz == 2'd1) begin
                    model[b] = d[7:0];
                end else begin
                    model[b]     = d[7:0];
                    model[b + 1] = d[15:8];
                end
            end else begin
                if (sz == 2'd0)
                    model_dato = {model[base+3], model[base+2], model[base+1], model[base]};
                else if (sz == 2'd1)
                    model_dato = {24'h0, model[b]};
                else
                    model_dato = {16'h0, model[b + 1], model[b]};
            end
        end
        dato = model_dato;
    endfunction

    // Cycle 0 is the cycle in which the request is presented; cycle 1 follows the
    // accepting edge. A completed access shows o_Listo in cycle W+2, an error in cycle 1.
    task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d, input int kind,
                           input logic [31:0] exp_dato, input string name);
        int   listo_cyc = -1;
        int   err_cyc   = -1;
        int   n_listo   = 0;
        int   n_err     = 0;
        int   cyc;
        logic busy1     = 1'b0;
        logic [31:0] act, exp;
        @(negedge clk);
        bus.i_Valido       = 1'b1;
        bus.i_LeerMem      = rd;
        bus.i_EscribirMem  = wr;
        bus.i_Tamano       = sz;
        bus.i_Direccion    = a;
        bus.i_DatoEscribir = d;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.i_Valido = 1'b0;
                busy1        = bus.o_Ocupado;
            end
            if (bus.o_Listo) begin
                n_listo++;
                if (listo_cyc < 0) listo_cyc = c;
            end
            if (bus.o_ErrorAlin) begin
                n_err++;
                if (err_cyc < 0) err_cyc = c;
            end
        end
        cyc = (n_listo > 0) ? listo_cyc : (n_err > 0) ? err_cyc : 255;
        act = {busy1, 7'h0, 8'(n_listo), 8'(n_err), 8'(cyc)};
        case (kind)
            1:       exp = {1'b1, 7'h0, 8'd1, 8'd0, 8'(W + 2)};
            2:       exp = {1'b1, 7'h0, 8'd0, 8'd1, 8'd1};
            default: exp = {1'b0, 7'h0, 8'd0, 8'd0, 8'd255};
        endcase
        check({name, " timing"}, act, exp);
        check({name, " dato"}, bus.o_DatoLeido, exp_dato);
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input string name);
        int k;
        logic [31:0] e;
        model_req(rd, wr, sz, a, d, k, e);
        run_req(rd, wr, sz, a, d, k, e, name);
    endtask

    initial begin
        int k;
        logic [31:0] e;
        logic [31:0] prior;
        int n_listo;

        rst                = 1'b1;
        bus.i_Valido       = 1'b0;
        bus.i_LeerMem      = 1'b0;
        bus.i_EscribirMem  = 1'b0;
        bus.i_Tamano       = 2'd0;
        bus.i_Direccion    = '0;
        bus.i_DatoEscribir = '0;
`ifdef MEMDATOS_DEBUG_EN
        dbg_dir = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset dato", bus.o_DatoLeido, 32'h0);
        check("reset flags", {29'h0, bus.o_Listo, bus.o_ErrorAlin, bus.o_Ocupado}, 32'h0);
        rst = 1'b0;

        // Give every word a known value; upper address bits exercise wrap-around.
        for (int i = 0; i < 256; i++)
            do_op(1'b0, 1'b1, 2'd0, {$urandom_range(0, 255), 14'h0, 8'(i), 2'b00}, $urandom,
                  "fill");

        tbl[0]  = '{1'b0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 1, 32'h00000000};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 32'h10, 32'h0,        1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 32'h11, 32'h0000007F, 1, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b0, 2'd1, 32'h11, 32'h0,        1, 32'h0000007F};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 32'h10, 32'h0,        1, 32'hDEAD7FEF};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 32'h12, 32'h0,        1, 32'h0000DEAD};
        tbl[6]  = '{1'b1, 1'b0, 2'd2, 32'h11, 32'h0,        2, 32'h0000DEAD};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 32'h10, 32'h0,        1, 32'hDEAD7FEF};
        tbl[8]  = '{1'b1, 1'b0, 2'd3, 32'h10, 32'h0,        2, 32'hDEAD7FEF};
        tbl[9]  = '{1'b1, 1'b1, 2'd0, 32'h30, 32'hCAFEF00D, 1, 32'hDEAD7FEF};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 32'h30, 32'h0,        1, 32'hCAFEF00D};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 32'h10, 32'h0,        0, 32'hCAFEF00D};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 32'h32, 32'hAAAA1234, 1, 32'hCAFEF00D};
        tbl[13] = '{1'b0, 1'b1, 2'd0, 32'h31, 32'h55555555, 2, 32'hCAFEF00D};
        tbl[14] = '{1'b1, 1'b0, 2'd0, 32'h30, 32'h0,        1, 32'h1234F00D};

        for (int i = 0; i < 15; i++) begin
            model_req(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].d, k, e);
            run_req(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].kind,
                    tbl[i].exp_dato, $sformatf("vec%0d", i));
        end

`ifdef MEMDATOS_DEBUG_EN
        dbg_dir = 8'd4;
        @(negedge clk);
        @(negedge clk);
        check("debug read", dbg_dato, {model[19], model[18], model[17], model[16]});
`endif

        // A request presented while busy must be ignored.
        @(negedge clk);
        bus.i_Valido      = 1'b1;
        bus.i_LeerMem     = 1'b1;
        bus.i_EscribirMem = 1'b0;
        bus.i_Tamano      = 2'd0;
        bus.i_Direccion   = 32'h10;
        n_listo           = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                bus.i_Valido       = 1'b1;
                bus.i_LeerMem      = 1'b0;
                bus.i_EscribirMem  = 1'b1;
                bus.i_DatoEscribir = 32'h11111111;
            end else begin
                bus.i_Valido = 1'b0;
            end
            if (bus.o_Listo) n_listo++;
        end
        model_req(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, k, e);
        check("busy pulses", 32'(n_listo), 32'd1);
        check("busy load", bus.o_DatoLeido, e);
        do_op(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, "busy unchanged");

        // Reset on the edge that would perform a store aborts it.
        prior = {model[35], model[34], model[33], model[32]};
        @(negedge clk);
        bus.i_Valido       = 1'b1;
        bus.i_LeerMem      = 1'b0;
        bus.i_EscribirMem  = 1'b1;
        bus.i_Tamano       = 2'd0;
        bus.i_Direccion    = 32'h20;
        bus.i_DatoEscribir = 32'h12345678;
        @(negedge clk);
        bus.i_Valido = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort dato", bus.o_DatoLeido, 32'h0);
        check("abort flags", {29'h0, bus.o_Listo, bus.o_ErrorAlin, bus.o_Ocupado}, 32'h0);
        rst        = 1'b0;
        model_dato = '0;
        run_req(1'b1, 1'b0, 2'd0, 32'h20, 32'h0, 1, prior, "abort prior");
        model_dato = prior;

        // Random requests against the model.
        for (int i = 0; i < 300; i++)
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $sformatf("rnd%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
